uart_tx_fifo: RTL and testbench
===============================

// Module: uart_tx_fifo
// PURPOSE
//   Buffered 8N1 UART transmitter driving usb_uart_txd of the SoC wrapper.
//   Bytes from the PS/AXI-side console path enter a FIFO over a valid/ready
//   handshake. They are serialised LSB-first at BAUD.
//   It is the stage directly upstream of the bench UART receiver that prints
//   FFT results to the terminal.
// PARAMETERS
//   CLK_FREQ    100000000  input clock frequency, Hz
//   BAUD        230400     line rate, bits/s
//   FIFO_DEPTH  16         byte FIFO depth; power of two, >= 2
//   (derived) CLKS_PER_BIT = CLK_FREQ/BAUD, integer division (434 at defaults)
// PORTS
//   clk         in   1                    system clock; all logic on rising edge
//   reset       in   1                    synchronous, active-high
//   s_data      in   8                    byte to transmit
//   s_valid     in   1                    s_data valid
//   s_ready     out  1                    FIFO can accept (not full)
//   txd         out  1                    serial line; idle high
//   busy        out  1                    frame in progress or FIFO non-empty
//   fifo_count  out  $clog2(FIFO_DEPTH)+1 bytes currently queued
// BEHAVIOUR
//   Reset (sync, active-high): txd=1, s_ready=1, busy=0, fifo_count=0, state=IDLE.
//     Any queued data is discarded.
//   Reset mid-frame: the frame is aborted. txd=1 from the edge where reset is sampled.
//   Handshake: write on an edge where s_valid&&s_ready. s_ready=!full, driven from
//     registered count. s_data is not required stable while s_ready=0.
//   FIFO: push and pop on the same edge -> count unchanged. Pointers wrap modulo
//     FIFO_DEPTH. Push when full is impossible (s_ready=0). Pop only when non-empty.
//   TX FSM, all outputs registered; bit counter 0..CLKS_PER_BIT-1:
//     IDLE : txd=1. If FIFO non-empty: pop, load shift reg, go to START.
//     START: txd=0 for CLKS_PER_BIT cycles, then go to DATA with bit_idx=0.
//     DATA : txd=shift[0] for CLKS_PER_BIT cycles, then shift right.
//            bit_idx 0..7. After bit 7, go to STOP.
//     STOP : txd=1 for CLKS_PER_BIT cycles, then go to IDLE.
//   Latency: txd falls on the edge after the pop edge in IDLE.
//     On an empty, idle block, the write is accepted at edge N, the byte pops at
//     edge N+1, and txd=0 from edge N+2.
//   Frame length is exactly 10*CLKS_PER_BIT cycles of low/data/high.
//   Back-to-back frames have one IDLE cycle between them, so the period is
//     10*CLKS_PER_BIT+1 cycles.
//   busy = (state!=IDLE) || (fifo_count!=0). busy goes low one cycle after STOP
//     completes with an empty FIFO.
//   Invalid state encoding -> IDLE, with txd=1.
// STRUCTURE
//   uart_pkg: TX state enum (IDLE/START/DATA/STOP) and a clks_per_bit(freq,baud)
//     function. uart_pkg is shared with the bench receiver model.
//   Sub-module sync_fifo #(WIDTH=8, DEPTH=FIFO_DEPTH):
//     - synchronous single-clock FIFO
//     - ports: wr_en, wr_data, rd_en, rd_data, full, empty, count
//     - rd_data is registered, valid the cycle after rd_en
//   uart_tx_fifo holds the FSM, baud counter, shift register and output registers.
// TESTING (sim with CLK_FREQ=1000, BAUD=100 -> CLKS_PER_BIT=10)
//   1 Single byte 0x55 into an idle block.
//     -> txd=0 at edge N+2, then bits 1,0,1,0,1,0,1,0, each 10 cycles.
//     -> Stop high for 10 cycles; busy low on the next cycle.
//   2 Back-to-back 'H' then 'i'.
//     -> The bench RX model prints "Hi".
//     -> Start bits are 101 cycles apart.
//   3 Push 17 bytes with s_valid held high while the line is stalled.
//     -> s_ready=0 once fifo_count=16.
//     -> The 17th byte is taken only after the first pop.
//     -> All 17 bytes are transmitted in order.
//   4 With fifo_count=16, push on the same edge as an IDLE pop.
//     -> Rejected (s_ready=0); count becomes 15.
//     -> With count=15, simultaneous push and pop leave count at 15.
//   5 Assert reset for 1 cycle during DATA bit 3.
//     -> txd=1 and fifo_count=0 next edge.
//     -> The next byte written is framed correctly.
//   6 Pattern 0x00 then 0xFF.
//     -> Low for 90 cycles, then high for 10.
//     -> 1 idle cycle, then 10 low and 90 high; RX decodes both bytes.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and the baud divisor helper.
// Also used by the bench receiver model.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  function automatic int clks_per_bit(input int freq, input int baud);
    return freq / baud;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock synchronous FIFO with a registered read port.
// rd_data is valid the cycle after an accepted rd_en.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             do_wr, do_rd;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    rd_data_d = rd_data_q;
    count_d   = count_q;
    if (do_wr) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (do_rd) begin
      rd_ptr_d  = rd_ptr_q + AW'(1);
      rd_data_d = mem[rd_ptr_q];
    end
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      rd_data_q <= rd_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

  assign rd_data = rd_data_q;
  assign count   = count_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: a byte FIFO fed over valid/ready, drained by an
// LSB-first serialiser. txd and busy are registered, one cycle behind the state.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD       = 230400,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [7:0]                  s_data,
  input  logic                        s_valid,
  output logic                        s_ready,
  output logic                        txd,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  tx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             txd_q, txd_d;
  logic             busy_q, busy_d;

  logic                        fifo_rd_en;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic [7:0]                  fifo_rd_data;
  logic [$clog2(FIFO_DEPTH):0] fifo_cnt;
  logic                        bit_done;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (s_valid),
    .wr_data (s_data),
    .rd_en   (fifo_rd_en),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_cnt)
  );

  assign s_ready    = !fifo_full;
  assign fifo_count = fifo_cnt;
  assign bit_done   = (cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      txd_q     <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      txd_q     <= txd_d;
      busy_q    <= busy_d;
    end
  end

  // The popped byte only appears on rd_data after the pop edge, so the shift
  // register is loaded while in START rather than on the pop itself.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    fifo_rd_en = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d     = '0;
        bit_idx_d = '0;
        if (!fifo_empty) begin
          fifo_rd_en = 1'b1;
          state_d    = START;
        end
      end
      START: begin
        shift_d = fifo_rd_data;
        if (bit_done) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (bit_done) begin
          cnt_d   = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (bit_done) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d   = IDLE;
        cnt_d     = '0;
        bit_idx_d = '0;
      end
    endcase
  end

  always_comb begin
    txd_d  = 1'b1;
    busy_d = (state_q != IDLE) || (fifo_cnt != '0);
    case (state_q)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_q[0];
      default: txd_d = 1'b1;
    endcase
  end

  assign txd  = txd_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomised self-checking bench for uart_tx_fifo: a queue/schedule reference model
// predicts every registered output each cycle, and an RX model decodes the line.
module tb_uart_tx_fifo;

  localparam int CLK_FREQ = 1000;
  localparam int BAUD     = 100;
  localparam int DEPTH    = 16;
  localparam int C        = CLK_FREQ / BAUD;
  localparam int FRAME    = 10 * C;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] s_data = 8'h00;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic       txd;
  logic       busy;
  logic [4:0] fifo_count;

  uart_tx_fifo #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD       (BAUD),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .txd        (txd),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  // Reference model: pending bytes plus the schedule of the frame on the line.
  logic [7:0] pend[$];
  bit         fr_active = 1'b0;
  int         fr_p = 0;
  logic [7:0] fr_byte = 8'h00;
  int         earliest_pop = 0;
  bit         last_accept = 1'b0;
  logic       exp_txd = 1'b1;
  logic       exp_ready = 1'b1;
  logic       exp_busy = 1'b0;
  int         exp_count = 0;

  // RX model state.
  bit         rx_active = 1'b0;
  int         rx_cnt = 0;
  logic [7:0] rx_shift = 8'h00;
  logic [7:0] rx_log[$];
  int         rx_starts[$];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic modelStep(input bit rst, input bit vld, input logic [7:0] dat);
    int  n_before;
    bit  in_frame_prev;
    int  k;
    int  b;
    n_before      = pend.size();
    in_frame_prev = fr_active && (cyc - 1 >= fr_p) && (cyc - 1 < fr_p + FRAME);
    if (rst) begin
      pend.delete();
      fr_active    = 1'b0;
      earliest_pop = 0;
      last_accept  = 1'b0;
      exp_busy     = 1'b0;
    end else begin
      exp_busy = in_frame_prev || (n_before != 0);
      if (n_before != 0 && cyc >= earliest_pop) begin
        fr_active    = 1'b1;
        fr_p         = cyc;
        fr_byte      = pend.pop_front();
        earliest_pop = cyc + FRAME + 1;
      end
      last_accept = vld && (n_before < DEPTH);
      if (last_accept) pend.push_back(dat);
    end
    exp_count = pend.size();
    exp_ready = (exp_count < DEPTH);
    exp_txd   = 1'b1;
    if (fr_active) begin
      k = cyc - fr_p - 1;
      if (k >= 0 && k < FRAME) begin
        b = k / C;
        if (b == 0)      exp_txd = 1'b0;
        else if (b == 9) exp_txd = 1'b1;
        else             exp_txd = fr_byte[b-1];
      end
    end
  endtask

  task automatic rxStep(input bit rst);
    if (rst) begin
      rx_active = 1'b0;
    end else if (!rx_active) begin
      if (txd === 1'b0) begin
        rx_active = 1'b1;
        rx_cnt    = 0;
        rx_starts.push_back(cyc);
      end
    end else begin
      rx_cnt++;
      if (rx_cnt == 9 * C + C / 2) begin
        checkOutput("rx_stop", {31'b0, txd}, 1);
        checkOutput("rx_byte", {24'b0, rx_shift}, {24'b0, fr_byte});
        rx_log.push_back(rx_shift);
        rx_active = 1'b0;
      end else if (rx_cnt % C == C / 2) begin
        rx_shift = {txd, rx_shift[7:1]};
      end
    end
  endtask

  always @(posedge clk) begin : monitor
    bit         r;
    bit         v;
    logic [7:0] d;
    cyc++;
    r = reset;
    v = s_valid;
    d = s_data;
    #1;
    modelStep(r, v, d);
    checkOutput("txd", {31'b0, txd}, {31'b0, exp_txd});
    checkOutput("s_ready", {31'b0, s_ready}, {31'b0, exp_ready});
    checkOutput("busy", {31'b0, busy}, {31'b0, exp_busy});
    checkOutput("fifo_count", {27'b0, fifo_count}, exp_count);
    rxStep(r);
  end

  task automatic applyStimulus(input logic [7:0] b, output int acc_cyc);
    int n;
    n       = 0;
    s_valid = 1'b1;
    s_data  = b;
    do begin
      @(negedge clk);
      n++;
    end while (!last_accept && n < 4000);
    acc_cyc = cyc;
    s_valid = 1'b0;
    if (!last_accept) checkOutput("accept_timeout", {31'b0, last_accept}, 1);
  endtask

  task automatic waitIdle(input int max_cycles);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(exp_busy == 1'b0 && pend.size() == 0) && n < max_cycles);
    checkOutput("drain_busy", {31'b0, busy}, 0);
  endtask

  task automatic waitUntil(input int target);
    int n;
    n = 0;
    while (cyc < target - 1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (cyc != target - 1) checkOutput("sync_edge", cyc, target - 1);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int         acc;
    int         s0;
    int         st0;
    logic [7:0] sent[$];
    logic [7:0] b;
    string      rx_str;

    repeat (3) @(negedge clk);
    checkOutput("reset_txd", {31'b0, txd}, 1);
    checkOutput("reset_ready", {31'b0, s_ready}, 1);
    checkOutput("reset_busy", {31'b0, busy}, 0);
    checkOutput("reset_count", {27'b0, fifo_count}, 0);
    reset = 1'b0;
    @(negedge clk);

    // Single byte: start bit two edges after acceptance.
    s0  = rx_log.size();
    st0 = rx_starts.size();
    applyStimulus(8'h55, acc);
    waitIdle(400);
    checkOutput("t1_frames", rx_log.size() - s0, 1);
    if (rx_starts.size() > st0) checkOutput("t1_latency", rx_starts[st0] - acc, 2);
    if (rx_log.size() > s0) checkOutput("t1_byte", {24'b0, rx_log[s0]}, 32'h55);

    // Back-to-back "Hi".
    s0  = rx_log.size();
    st0 = rx_starts.size();
    applyStimulus(8'h48, acc);
    applyStimulus(8'h69, acc);
    waitIdle(600);
    checkOutput("t2_frames", rx_log.size() - s0, 2);
    if (rx_log.size() >= s0 + 2) begin
      rx_str = $sformatf("%c%c", rx_log[s0], rx_log[s0+1]);
      $display("[TB] RX model printed \"%s\"", rx_str);
      checkOutput("t2_h", {24'b0, rx_log[s0]}, 32'h48);
      checkOutput("t2_i", {24'b0, rx_log[s0+1]}, 32'h69);
    end
    if (rx_starts.size() >= st0 + 2)
      checkOutput("t2_spacing", rx_starts[st0+1] - rx_starts[st0], FRAME + 1);

    // Fill the FIFO behind a busy line, then overflow by one.
    s0 = rx_log.size();
    sent.delete();
    for (int i = 0; i < 17; i++) begin
      b = 8'($urandom);
      sent.push_back(b);
      applyStimulus(b, acc);
    end
    checkOutput("t3_full_count", {27'b0, fifo_count}, DEPTH);
    checkOutput("t3_ready_low", {31'b0, s_ready}, 0);
    b = 8'($urandom);
    sent.push_back(b);
    applyStimulus(b, acc);
    checkOutput("t3_late_accept", acc, fr_p + 1);

    // Push on a pop edge while full is rejected; at 15, push+pop holds 15.
    waitUntil(earliest_pop);
    s_valid = 1'b1;
    s_data  = 8'($urandom);
    @(negedge clk);
    s_valid = 1'b0;
    checkOutput("t4_full_pop_count", {27'b0, fifo_count}, DEPTH - 1);
    waitUntil(earliest_pop);
    s_valid = 1'b1;
    s_data  = 8'h3C;
    sent.push_back(8'h3C);
    @(negedge clk);
    s_valid = 1'b0;
    checkOutput("t4_pushpop_count", {27'b0, fifo_count}, DEPTH - 1);
    waitIdle(4000);
    checkOutput("t3_frames", rx_log.size() - s0, sent.size());
    for (int i = 0; i < sent.size(); i++) begin
      if (s0 + i < rx_log.size())
        checkOutput("t3_order", {24'b0, rx_log[s0+i]}, {24'b0, sent[i]});
    end

    // Reset during DATA bit 3 with bytes still queued.
    applyStimulus(8'hC3, acc);
    applyStimulus(8'h11, acc);
    applyStimulus(8'h22, acc);
    waitUntil(fr_p + 4 * C + 5);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("t5_txd", {31'b0, txd}, 1);
    checkOutput("t5_count", {27'b0, fifo_count}, 0);
    s0 = rx_log.size();
    applyStimulus(8'hA5, acc);
    waitIdle(400);
    checkOutput("t5_frames", rx_log.size() - s0, 1);
    if (rx_log.size() > s0) checkOutput("t5_byte", {24'b0, rx_log[s0]}, 32'hA5);

    // All-zero then all-one bytes.
    s0 = rx_log.size();
    applyStimulus(8'h00, acc);
    applyStimulus(8'hFF, acc);
    waitIdle(600);
    checkOutput("t6_frames", rx_log.size() - s0, 2);
    if (rx_log.size() >= s0 + 2) begin
      checkOutput("t6_zero", {24'b0, rx_log[s0]}, 32'h00);
      checkOutput("t6_ones", {24'b0, rx_log[s0+1]}, 32'hFF);
    end

    // Random traffic with occasional resets.
    for (int i = 0; i < 2500; i++) begin
      reset   = ($urandom_range(0, 799) == 0);
      s_valid = ($urandom_range(0, 2) == 0);
      s_data  = 8'($urandom);
      @(negedge clk);
    end
    reset   = 1'b0;
    s_valid = 1'b0;
    waitIdle(5000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
